program_loader: RTL and testbench

Sequential boot loader sitting upstream of the single-cycle core and both BRAMs. It accepts a valid/ready word stream from a host link and parses a header, data words and instruction words. It drives the write ports of the data and instruction BRAMs, then releases the core by dropping `pc_stall` and asserting the read enables. It replaces the hand-driven init loops currently used to bring up every instruction-level bench.

---
 rtl/program_loader_pkg.sv | 26 ++
 rtl/program_loader.sv | 171 +++++++++++++++++
 tb/tb_program_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot loader: word width, header field
// positions and the loader state encoding.
// Optional build macro: PROGRAM_LOADER_CHECKSUM_EN adds the CHECK state.
package program_loader_pkg;

   localparam int unsigned DATA_WIDTH = 32;

   // Header word: data word count in the upper half, instruction count below.
   localparam int unsigned LDR_HDR_ND_MSB = 31;
   localparam int unsigned LDR_HDR_ND_LSB = 16;
   localparam int unsigned LDR_HDR_NI_MSB = 15;
   localparam int unsigned LDR_HDR_NI_LSB = 0;

   typedef enum logic [2:0] {
      LDR_IDLE,
      LDR_HEADER,
      LDR_DATA,
      LDR_INSTR,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      LDR_CHECK,
`endif
      LDR_DONE,
      LDR_ERROR
   } ldr_state_t;

endpackage

// File: rtl/program_loader.sv
// Sequential boot loader: parses a header/data/instruction word stream,
// writes both BRAMs, then releases the core (pc_stall low, reads enabled).
// Optional build macro: PROGRAM_LOADER_CHECKSUM_EN appends an XOR checksum
// word that must match the header and all payload words.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned ADDR_W = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic [ADDR_W-1:0]     d_w_addr,
   output logic [DATA_WIDTH-1:0] d_w_dat,
   output logic                  d_w_enb,
   output logic [3:0]            d_w_byte_enb,
   output logic [ADDR_W-1:0]     i_w_addr,
   output logic [DATA_WIDTH-1:0] i_w_dat,
   output logic                  i_w_enb,
   output logic [3:0]            i_w_byte_enb,
   output logic                  d_bram_init_done,
   output logic                  pc_stall,
   output logic                  rd_enbl,
   output logic                  i_r_enb,
   output logic                  busy,
   output logic                  error
);

   localparam logic [15:0] DEPTH_W = 16'(DEPTH);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam ldr_state_t FIN_STATE = LDR_CHECK;
`else
   localparam ldr_state_t FIN_STATE = LDR_DONE;
`endif

   ldr_state_t  state, state_nxt;
   logic [15:0] cnt, nd, ni;
   logic [15:0] hdr_nd, hdr_ni;
   logic        accept, d_wr, i_wr;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum;
`endif

   assign hdr_nd = s_data[LDR_HDR_ND_MSB:LDR_HDR_ND_LSB];
   assign hdr_ni = s_data[LDR_HDR_NI_MSB:LDR_HDR_NI_LSB];
   assign accept = s_valid & s_ready;
   assign d_wr   = accept & (state == LDR_DATA);
   assign i_wr   = accept & (state == LDR_INSTR);

   // State register, per-section word counter and latched header counts.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LDR_IDLE;
         cnt   <= '0;
         nd    <= '0;
         ni    <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum  <= '0;
`endif
      end else begin
         state <= state_nxt;
         // Any state change is a section entry, so the counter restarts there.
         if (state_nxt != state)
            cnt <= '0;
         else if (accept)
            cnt <= cnt + 16'd1;
         if (accept && state == LDR_HEADER) begin
            nd <= hdr_nd;
            ni <= hdr_ni;
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         if (accept && state == LDR_HEADER)
            csum <= s_data;
         else if (accept)
            csum <= csum ^ s_data;
`endif
      end
   end

   // Registered BRAM write ports: one write per accepted payload word.
   always_ff @(posedge clk) begin
      if (rst) begin
         d_w_enb      <= 1'b0;
         d_w_addr     <= '0;
         d_w_dat      <= '0;
         d_w_byte_enb <= '0;
         i_w_enb      <= 1'b0;
         i_w_addr     <= '0;
         i_w_dat      <= '0;
         i_w_byte_enb <= '0;
      end else begin
         d_w_enb      <= d_wr;
         d_w_addr     <= d_wr ? ADDR_W'({cnt[9:0], 2'b00}) : '0;
         d_w_dat      <= d_wr ? s_data : '0;
         d_w_byte_enb <= d_wr ? 4'b1111 : 4'b0000;
         i_w_enb      <= i_wr;
         i_w_addr     <= i_wr ? ADDR_W'({cnt[9:0], 2'b00}) : '0;
         i_w_dat      <= i_wr ? s_data : '0;
         i_w_byte_enb <= i_wr ? 4'b1111 : 4'b0000;
      end
   end

   // Next-state decode and state-derived handshake/status outputs.
   always_comb begin
      state_nxt        = state;
      s_ready          = 1'b0;
      busy             = 1'b0;
      error            = 1'b0;
      pc_stall         = 1'b1;
      d_bram_init_done = 1'b0;
      rd_enbl          = 1'b0;
      i_r_enb          = 1'b0;
      case (state)
         LDR_IDLE: begin
            if (start) state_nxt = LDR_HEADER;
         end
         LDR_HEADER: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (accept) begin
               if (hdr_nd > DEPTH_W || hdr_ni > DEPTH_W)
                  state_nxt = LDR_ERROR;
               else if (hdr_nd != '0)
                  state_nxt = LDR_DATA;
               else if (hdr_ni != '0)
                  state_nxt = LDR_INSTR;
               else
                  state_nxt = FIN_STATE;
            end
         end
         LDR_DATA: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (accept && (cnt + 16'd1) == nd)
               state_nxt = (ni != '0) ? LDR_INSTR : FIN_STATE;
         end
         LDR_INSTR: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (accept && (cnt + 16'd1) == ni)
               state_nxt = FIN_STATE;
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         LDR_CHECK: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (accept)
               state_nxt = (s_data == csum) ? LDR_DONE : LDR_ERROR;
         end
`endif
         LDR_DONE: begin
            pc_stall         = 1'b0;
            d_bram_init_done = 1'b1;
            rd_enbl          = 1'b1;
            i_r_enb          = 1'b1;
            if (start) state_nxt = LDR_HEADER;
         end
         LDR_ERROR: begin
            error = 1'b1;
            if (start) state_nxt = LDR_HEADER;
         end
         default: state_nxt = LDR_IDLE;
      endcase
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard: each driven
// word pushes its expected BRAM write, popped and compared one cycle later.
// Honours PROGRAM_LOADER_CHECKSUM_EN by appending the XOR checksum word.
module tb_program_loader;
   import program_loader_pkg::*;

   localparam logic [6:0] ST_IDLE = 7'b0001000;
   localparam logic [6:0] ST_RUN  = 7'b1101000;
   localparam logic [6:0] ST_DONE = 7'b0000111;
   localparam logic [6:0] ST_ERR  = 7'b0011000;

   logic        clk = 1'b0;
   logic        rst, start, s_valid, s_ready;
   logic [31:0] s_data;
   logic [11:0] d_w_addr, i_w_addr;
   logic [31:0] d_w_dat, i_w_dat;
   logic        d_w_enb, i_w_enb;
   logic [3:0]  d_w_byte_enb, i_w_byte_enb;
   logic        d_bram_init_done, pc_stall, rd_enbl, i_r_enb, busy, error;

   typedef struct {
      bit          d;
      bit          i;
      logic [11:0] addr;
      logic [31:0] dat;
   } wr_t;

   wr_t         exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] csum_m;

   always #5 clk = ~clk;

   program_loader #(.DEPTH(1024), .ADDR_W(12)) dut (
      .clk(clk), .rst(rst), .start(start),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
      .d_w_byte_enb(d_w_byte_enb),
      .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
      .i_w_byte_enb(i_w_byte_enb),
      .d_bram_init_done(d_bram_init_done), .pc_stall(pc_stall),
      .rd_enbl(rd_enbl), .i_r_enb(i_r_enb), .busy(busy), .error(error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic status(input string tag, input logic [6:0] exp);
      chk(tag, 32'({s_ready, busy, error, pc_stall, d_bram_init_done, rd_enbl, i_r_enb}),
          32'(exp));
   endtask

   // Advance one cycle, then check the write ports against the scoreboard.
   task automatic tick();
      wr_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("d_w_enb", 32'(d_w_enb), 32'(e.d));
         chk("i_w_enb", 32'(i_w_enb), 32'(e.i));
         chk("d_w_byte_enb", 32'(d_w_byte_enb), e.d ? 32'hF : 32'h0);
         chk("i_w_byte_enb", 32'(i_w_byte_enb), e.i ? 32'hF : 32'h0);
         if (e.d) begin
            chk("d_w_addr", 32'(d_w_addr), 32'(e.addr));
            chk("d_w_dat", d_w_dat, e.dat);
         end
         if (e.i) begin
            chk("i_w_addr", 32'(i_w_addr), 32'(e.addr));
            chk("i_w_dat", i_w_dat, e.dat);
         end
      end else begin
         chk("idle_w_enb", 32'({d_w_enb, i_w_enb}), 32'h0);
         chk("idle_byte_enb", 32'({d_w_byte_enb, i_w_byte_enb}), 32'h0);
      end
   endtask

   task automatic send(input logic [31:0] w, input bit d, input bit i, input logic [11:0] a);
      wr_t e;
      s_valid = 1'b1;
      s_data  = w;
      chk("s_ready", 32'(s_ready), 32'h1);
      e.d = d; e.i = i; e.addr = a; e.dat = w;
      exp_q.push_back(e);
      csum_m = csum_m ^ w;
      tick();
   endtask

   task automatic gap();
      s_valid = 1'b0;
      s_data  = 32'hDEADBEEF;
      chk("gap_ready", 32'(s_ready), 32'h1);
      tick();
   endtask

   task automatic do_start();
      s_valid = 1'b0;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      status("start_status", ST_RUN);
   endtask

   task automatic load(input logic [15:0] nd, input logic [15:0] ni, input bit gaps);
      csum_m = '0;
      send({nd, ni}, 1'b0, 1'b0, 12'h0);
      for (int unsigned k = 0; k < 32'(nd); k++) begin
         if (gaps) gap();
         send(32'hAAAA0000 + 32'(k), 1'b1, 1'b0, 12'(k * 4));
      end
      for (int unsigned k = 0; k < 32'(ni); k++) begin
         if (gaps) gap();
         send(32'h11 * (k + 1), 1'b0, 1'b1, 12'(k * 4));
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (gaps) gap();
      send(csum_m, 1'b0, 1'b0, 12'h0);
`endif
      status("load_done", ST_DONE);
      s_valid = 1'b0;
      tick();
      status("done_hold", ST_DONE);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; csum_m = '0;
      tick();
      tick();
      status("reset_status", ST_IDLE);
      chk("reset_addr", 32'({d_w_addr, i_w_addr}), 32'h0);
      chk("reset_d_dat", d_w_dat, 32'h0);
      chk("reset_i_dat", i_w_dat, 32'h0);
      rst = 1'b0;
      tick();
      status("idle_status", ST_IDLE);

      // Full load, valid held high.
      do_start();
      load(16'd2, 16'd3, 1'b0);

      // Same payload, valid toggled.
      do_start();
      load(16'd2, 16'd3, 1'b1);

      // Oversized data count, then recovery.
      do_start();
      send(32'h0401_0001, 1'b0, 1'b0, 12'h0);
      status("err_nd", ST_ERR);
      s_valid = 1'b1; s_data = 32'h1234_5678;
      tick();
      status("err_hold", ST_ERR);
      do_start();
      load(16'd1, 16'd1, 1'b0);

      // Oversized instruction count.
      do_start();
      send(32'h0000_0401, 1'b0, 1'b0, 12'h0);
      status("err_ni", ST_ERR);

      // Empty program.
      do_start();
      load(16'd0, 16'd0, 1'b0);

      // Maximum data count, last slot 0xFFC.
      do_start();
      load(16'd1024, 16'd0, 1'b0);

      // Reset in the middle of the instruction section.
      do_start();
      csum_m = '0;
      send(32'h0000_0003, 1'b0, 1'b0, 12'h0);
      send(32'h11, 1'b0, 1'b1, 12'h0);
      s_valid = 1'b0;
      rst = 1'b1;
      tick();
      status("midrst_status", ST_IDLE);
      chk("midrst_addr", 32'({d_w_addr, i_w_addr}), 32'h0);
      chk("midrst_dat", i_w_dat, 32'h0);
      rst = 1'b0;
      tick();
      status("midrst_idle", ST_IDLE);
      do_start();
      load(16'd0, 16'd3, 1'b0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      do_start();
      send(32'h0000_0001, 1'b0, 1'b0, 12'h0);
      send(32'h0050_0293, 1'b0, 1'b1, 12'h0);
      send(32'h0050_0292, 1'b0, 1'b0, 12'h0);
      status("csum_ok", ST_DONE);
      do_start();
      send(32'h0000_0001, 1'b0, 1'b0, 12'h0);
      send(32'h0050_0293, 1'b0, 1'b1, 12'h0);
      send(32'h0000_0000, 1'b0, 1'b0, 12'h0);
      status("csum_bad", ST_ERR);
`endif

      s_valid = 1'b0;
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
